// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB3 requester bridge.
// Holds the transfer state encoding, default bus widths and the wait-timer width helper.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int DW_DEFAULT      = 32;
  localparam int AW_DEFAULT      = 12;
  localparam int TIMEOUT_DEFAULT = 64;

  // Counter must be able to hold the limit value itself.
  function automatic int timer_width(input int limit);
    return $clog2(limit + 1);
  endfunction

  localparam int TIMER_W_DEFAULT = timer_width(TIMEOUT_DEFAULT);

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-cycle counter for the APB requester bridge.
// Used only when APB_MASTER_TIMEOUT_EN is defined. 'expired' flags the wait
// cycle that brings the count to LIMIT, so the caller can abort in that cycle.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT,
  parameter int W     = timer_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [W-1:0] cnt;

  // Wait counter: cleared on ACCESS entry, saturates at LIMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (clear) begin
      cnt <= {W{1'b0}};
    end else if (count && (cnt != W'(LIMIT))) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // Current wait cycle is the LIMIT-th one.
  always_comb begin
    expired = count && (cnt == W'(LIMIT - 1));
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: valid/ready command in, one APB transfer, valid/ready response out.
// One transfer in flight, all outputs registered, synchronous active-high PRESET.
// Optional ACCESS-phase abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int DW             = DW_DEFAULT,
  parameter int AW             = AW_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] PADDR,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e    state;
  apb_state_e    next_state;
  logic          accept;
  logic          done;
  logic          abort;
  logic          expired;
  logic          cmd_ready_d;
  logic          psel_d;
  logic          penable_d;
  logic          pwrite_d;
  logic          rsp_valid_d;
  logic          rsp_err_d;
  logic [AW-1:0] paddr_d;
  logic [DW-1:0] pwdata_d;
  logic [DW-1:0] rsp_rdata_d;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;
  assign done   = (state == ACCESS) && PREADY;
  assign abort  = (state == ACCESS) && !PREADY && expired;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (state == SETUP),
    .count  ((state == ACCESS) && !PREADY),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= {AW{1'b0}};
      PWDATA    <= {DW{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DW{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= cmd_ready_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Transfer sequencing: IDLE -> SETUP -> ACCESS (waits) -> RESP (held until consumed).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = accept ? SETUP : IDLE;
      SETUP:   next_state = ACCESS;
      ACCESS:  next_state = (done || abort) ? RESP : ACCESS;
      RESP:    next_state = rsp_ready ? IDLE : RESP;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    cmd_ready_d = (next_state == IDLE);
    psel_d      = (next_state == SETUP) || (next_state == ACCESS);
    penable_d   = (next_state == ACCESS);
    rsp_valid_d = (next_state == RESP);
    if (accept) begin
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_write ? cmd_wdata : {DW{1'b0}};
    end else begin
      paddr_d  = PADDR;
      pwrite_d = PWRITE;
      pwdata_d = PWDATA;
    end
    if (done) begin
      rsp_rdata_d = PWRITE ? {DW{1'b0}} : PRDATA;
      rsp_err_d   = PSLVERR;
    end else if (abort) begin
      rsp_rdata_d = {DW{1'b0}};
      rsp_err_d   = 1'b1;
    end else begin
      rsp_rdata_d = rsp_rdata;
      rsp_err_d   = rsp_err;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed items then randomized traffic,
// compared every cycle against a transaction-timeline model with a small memory slave.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master_bridge #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // One command plus the slave/consumer behaviour to apply to it.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            w;         // PREADY=0 ACCESS cycles before completion
    logic          err;       // PSLVERR on the completing cycle
    int            rr;        // cycles rsp_ready is held low in RESP
    int            rst_off;   // >0: pulse PRESET this many edges after accept
    int            gap;       // idle cycles before offering the command
    bit            lit;
    logic [DW-1:0] lit_rdata;
    logic          lit_err;
    int            lit_lat;   // accept cycle to first rsp_valid cycle
  } item_t;

  item_t         q[$];
  logic [DW-1:0] mem [16];
  int            tests = 0;
  int            fails = 0;
  int            e = 0;
  int            n_pop = 0;
  int            n_dir = 0;
  int            init_rst = 3;

  // Model state: the transaction in flight described by its timeline.
  bit            busy = 1'b0;
  bit            m_ready = 1'b0;
  bit            after_rst = 1'b0;
  bit            timed_out;
  int            t_acc, t_end;
  item_t         cur;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s edge %0d: got %0h expected %0h", name, e, act, exp);
    end
  endtask

  function automatic item_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               input int w, input logic err, input int rr, input int rst_off,
                               input bit lit, input logic [DW-1:0] lr, input logic le, input int ll);
    item_t it;
    it.wr = wr; it.addr = addr; it.wdata = wd; it.w = w; it.err = err; it.rr = rr;
    it.rst_off = rst_off; it.gap = 0; it.lit = lit; it.lit_rdata = lr; it.lit_err = le;
    it.lit_lat = ll;
    return it;
  endfunction

  task automatic compare();
    bit exp_psel, exp_pen, exp_rv;
    exp_psel = busy && (e >= t_acc) && (e <= t_end - 1);
    exp_pen  = busy && (e >= t_acc + 1) && (e <= t_end - 1);
    exp_rv   = busy && (e >= t_end);
    chk("cmd_ready", cmd_ready, m_ready);
    chk("psel", PSEL, exp_psel);
    chk("penable", PENABLE, exp_pen);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (exp_psel) begin
      chk("paddr", PADDR, cur.addr);
      chk("pwrite", PWRITE, cur.wr);
      chk("pwdata", PWDATA, cur.wr ? cur.wdata : {DW{1'b0}});
    end
    if (exp_rv) begin
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_err", rsp_err, exp_err);
    end
    if (busy && cur.lit && (e == t_end)) begin
      chk("lit_latency", t_end + 1 - t_acc, cur.lit_lat);
      chk("lit_rdata", rsp_rdata, cur.lit_rdata);
      chk("lit_err", rsp_err, cur.lit_err);
    end
  endtask

  // Inputs for the cycle following edge e.
  task automatic drive();
    bit in_access, completing;
    PRESET = 1'b0;
    if (init_rst > 0) begin
      PRESET = 1'b1;
      init_rst--;
    end else if (busy && cur.rst_off > 0 && e == t_acc + cur.rst_off) begin
      PRESET = 1'b1;
    end else if (n_pop >= n_dir && $urandom_range(0, 199) == 0) begin
      PRESET = 1'b1;
    end
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    if (q.size() > 0) begin
      if (q[0].gap > 0 && !busy) begin
        q[0].gap = q[0].gap - 1;
      end else begin
        cmd_valid = 1'b1;
        cmd_write = q[0].wr;
        cmd_addr  = q[0].addr;
        cmd_wdata = q[0].wdata;
      end
    end
    in_access  = busy && (e >= t_acc + 1) && (e <= t_end - 1);
    completing = in_access && (e + 1 == t_end) && !timed_out;
    if (in_access) begin
      PREADY  = completing;
      PSLVERR = completing ? cur.err : 1'b1;
      PRDATA  = (completing && !cur.wr) ? mem[cur.addr[5:2]] : $urandom;
    end else begin
      PREADY  = 1'($urandom);
      PSLVERR = 1'($urandom);
      PRDATA  = $urandom;
    end
    if (busy && e >= t_end) rsp_ready = ((e - t_end) >= cur.rr);
    else rsp_ready = 1'($urandom);
  endtask

  // Advance one clock edge, update the model, compare, then drive the next inputs.
  task automatic step();
    bit hs;
    @(posedge PCLK);
    #1;
    e++;
    if (PRESET) begin
      busy = 1'b0;
      m_ready = 1'b0;
      after_rst = 1'b1;
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
    end else begin
      if (after_rst) begin
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);
        after_rst = 1'b0;
      end
      if (busy && e == t_end && !timed_out && cur.wr && !cur.err)
        mem[cur.addr[5:2]] = cur.wdata;
      hs = busy && (e - 1 >= t_end) && rsp_ready;
      if (hs) busy = 1'b0;
      if (m_ready && cmd_valid) begin
        cur = q.pop_front();
        n_pop++;
        busy = 1'b1;
        t_acc = e;
        timed_out = TO_EN && (cur.w >= TO);
        t_end = timed_out ? (e + 1 + TO) : (e + 2 + cur.w);
        exp_err = timed_out ? 1'b1 : cur.err;
        exp_rdata = (timed_out || cur.wr) ? {DW{1'b0}} : mem[cur.addr[5:2]];
      end
      m_ready = !busy;
    end
    compare();
    drive();
  endtask

  initial begin
    item_t it;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[4] = 32'h1234_5678;
    q.push_back(mk(1'b1, 12'h008, 32'hDEAD_BEEF, 0, 1'b0, 0, 0, 1'b1, 32'h0, 1'b0, 3));
    q.push_back(mk(1'b0, 12'h008, 32'h0,         0, 1'b0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3));
    q.push_back(mk(1'b0, 12'h010, 32'h0,         5, 1'b0, 0, 0, 1'b1, 32'h1234_5678, 1'b0, 8));
    q.push_back(mk(1'b1, 12'h020, 32'hCAFE_F00D, 2, 1'b1, 0, 0, 1'b1, 32'h0, 1'b1, 5));
    q.push_back(mk(1'b0, 12'h008, 32'h0,         0, 1'b0, 10, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3));
    q.push_back(mk(1'b0, 12'h004, 32'h0,         6, 1'b0, 0, 3, 1'b0, 32'h0, 1'b0, 0));
    if (TO_EN) q.push_back(mk(1'b0, 12'h00C, 32'h0, 20, 1'b0, 0, 0, 1'b1, 32'h0, 1'b1, TO + 2));
    n_dir = q.size();
    for (int i = 0; i < 250; i++) begin
      it = mk(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 7),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 0, 1'b0, 32'h0, 1'b0, 0);
      it.gap = $urandom_range(0, 2);
      q.push_back(it);
    end
    drive();
    while ((init_rst > 0 || q.size() > 0 || busy) && e < 20000) step();
    if (e >= 20000) begin
      tests++;
      fails++;
      $display("FAIL run_bound: got %0d edges, limit 20000 with %0d items left", e, q.size());
    end
    for (int i = 0; i < 3; i++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
